// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite line scanner: table entry,
// scan-list entry, FSM encoding and the line-coverage test.
package sprite_pkg;

  localparam int NUM_SPRITES = 32;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int SEL_W       = 5;
  localparam int ROW_W       = 4;

  typedef struct packed {
    logic           vis;
    logic           attr;
    logic           pos;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [X_W-1:0]   x;
    logic [ROW_W-1:0] row;
    logic             attr;
    logic             pos;
  } list_entry_t;

  // One bit wider than a line number so y + height never wraps past line 511.
  function automatic logic sprite_covers(input sprite_entry_t e,
                                         input logic [Y_W-1:0] line,
                                         input logic [Y_W:0]   height);
    logic [Y_W:0] top;
    logic [Y_W:0] bot;
    logic [Y_W:0] ln;
    top = {1'b0, e.y};
    bot = top + height;
    ln  = {1'b0, line};
    return e.vis && (ln >= top) && (ln < bot);
  endfunction

endpackage

// File: rtl/sprite_table.sv
// 32-entry sprite attribute table: synchronous write, combinational read,
// asynchronous clear of every entry.
module sprite_table
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [SEL_W-1:0]     wr_sel,
  input  sprite_entry_t        wr_data,
  input  logic [SEL_W-1:0]     rd_sel,
  output sprite_entry_t        rd_data
);

  sprite_entry_t mem [NUM_SPRITES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_sel] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a write to the entry being scanned
  // in the same cycle is not observed by that evaluation.
  assign rd_data = mem[rd_sel];

endmodule

// File: rtl/sprite_line_scan.sv
// Sprite line scanner: walks the attribute table once per scanline request
// and builds an ordered list of up to MAX_HITS covering sprites.
module sprite_line_scan
  import sprite_pkg::*;
#(
  parameter int SPR_H    = 16,
  parameter int MAX_HITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sprite_wr,
  input  logic [4:0]                    sprite_sel,
  input  logic [9:0]                    sprite_x,
  input  logic [8:0]                    sprite_y,
  input  logic                          sprite_vis,
  input  logic                          sprite_attr,
  input  logic                          sprite_pos,
  input  logic                          line_start,
  input  logic [8:0]                    line_y,
  input  logic [$clog2(MAX_HITS)-1:0]   rd_idx,
  output logic                          list_valid,
  output logic [$clog2(MAX_HITS+1)-1:0] hit_count,
  output logic                          overflow,
  output logic [4:0]                    rd_sel,
  output logic [9:0]                    rd_x,
  output logic [3:0]                    rd_row,
  output logic                          rd_attr,
  output logic                          rd_pos,
  output logic [1:0]                    dbg_state
);

  localparam int                HC_W     = $clog2(MAX_HITS + 1);
  localparam int                RI_W     = $clog2(MAX_HITS);
  localparam logic [HC_W-1:0]   HC_MAX   = HC_W'(MAX_HITS);
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_SPRITES - 1);

  // Handshake: line_start is a one-cycle request with no back-pressure; it is
  // always accepted and restarts any scan. list_valid is a level that is high
  // from the end of a complete scan until the next line_start or reset.

  scan_state_t       state, state_n;
  logic [SEL_W-1:0]  scan_idx;
  logic [Y_W-1:0]    line_q;
  sprite_entry_t     wr_entry;
  sprite_entry_t     scan_entry;
  logic              scan_hit;
  list_entry_t       new_item;
  list_entry_t       rd_q;
  list_entry_t       list_q [MAX_HITS];

  assign wr_entry = '{vis: sprite_vis, attr: sprite_attr, pos: sprite_pos,
                      y: sprite_y, x: sprite_x};

  sprite_table u_table (
    .clk     (clk),
    .reset   (reset),
    .wr      (sprite_wr),
    .wr_sel  (sprite_sel),
    .wr_data (wr_entry),
    .rd_sel  (scan_idx),
    .rd_data (scan_entry)
  );

  assign scan_hit = sprite_covers(scan_entry, line_q, (Y_W+1)'(SPR_H));

  always_comb begin
    new_item      = '0;
    new_item.sel  = scan_idx;
    new_item.x    = scan_entry.x;
    new_item.row  = ROW_W'(line_q - scan_entry.y);
    new_item.attr = scan_entry.attr;
    new_item.pos  = scan_entry.pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (line_start) begin
      state_n = SCAN;
    end else begin
      case (state)
        SCAN:    if (scan_idx == LAST_IDX) state_n = DONE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_q     <= '0;
      scan_idx   <= '0;
      hit_count  <= '0;
      overflow   <= 1'b0;
      list_valid <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) list_q[i] <= '0;
    end else if (line_start) begin
      line_q     <= line_y;
      scan_idx   <= '0;
      hit_count  <= '0;
      overflow   <= 1'b0;
      list_valid <= 1'b0;
    end else if (state == SCAN) begin
      if (scan_hit) begin
        if (hit_count < HC_MAX) begin
          list_q[hit_count[RI_W-1:0]] <= new_item;
          hit_count                   <= hit_count + HC_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      scan_idx <= scan_idx + SEL_W'(1);
      if (scan_idx == LAST_IDX) list_valid <= 1'b1;
    end
  end

  // Stale list slots beyond hit_count are masked rather than cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else if (HC_W'(rd_idx) < hit_count) begin
      rd_q <= list_q[rd_idx];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_sel    = rd_q.sel;
  assign rd_x      = rd_q.x;
  assign rd_row    = rd_q.row;
  assign rd_attr   = rd_q.attr;
  assign rd_pos    = rd_q.pos;
  assign dbg_state = state;

endmodule

// File: tb/tb_sprite_line_scan.sv
// Randomized scoreboard bench for sprite_line_scan with a list-based
// reference model of the sprite table and scanline hit rules.
module tb_sprite_line_scan;

  localparam int SPR_H    = 16;
  localparam int MAX_HITS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sprite_wr = 1'b0;
  logic [4:0] sprite_sel = '0;
  logic [9:0] sprite_x = '0;
  logic [8:0] sprite_y = '0;
  logic       sprite_vis = 1'b0;
  logic       sprite_attr = 1'b0;
  logic       sprite_pos = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = '0;
  logic [2:0] rd_idx = '0;
  logic       list_valid;
  logic [3:0] hit_count;
  logic       overflow;
  logic [4:0] rd_sel;
  logic [9:0] rd_x;
  logic [3:0] rd_row;
  logic       rd_attr;
  logic       rd_pos;
  logic [1:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sprite_line_scan #(.SPR_H(SPR_H), .MAX_HITS(MAX_HITS)) dut (
    .clk(clk), .reset(reset), .sprite_wr(sprite_wr), .sprite_sel(sprite_sel),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_vis(sprite_vis),
    .sprite_attr(sprite_attr), .sprite_pos(sprite_pos), .line_start(line_start),
    .line_y(line_y), .rd_idx(rd_idx), .list_valid(list_valid),
    .hit_count(hit_count), .overflow(overflow), .rd_sel(rd_sel), .rd_x(rd_x),
    .rd_row(rd_row), .rd_attr(rd_attr), .rd_pos(rd_pos), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int m_vis[32], m_y[32], m_x[32], m_attr[32], m_pos[32];
  int s_vis[32], s_y[32], s_x[32], s_attr[32], s_pos[32];
  int el_sel[MAX_HITS], el_x[MAX_HITS], el_row[MAX_HITS];
  int el_attr[MAX_HITS], el_pos[MAX_HITS];
  int el_count;
  int scanning, scan_k, m_line;

  logic [4:0]  sum_exp_q[$];
  logic [20:0] rd_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic rd_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_vis[i] = 0; m_y[i] = 0; m_x[i] = 0; m_attr[i] = 0; m_pos[i] = 0;
    end
    scanning = 0;
    scan_k   = 0;
    el_count = 0;
  endtask

  // Build the expected list from the per-entry values each evaluation saw.
  task automatic model_finish_scan();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (s_vis[i] != 0 && m_line >= s_y[i] && m_line < s_y[i] + SPR_H) begin
        if (n < MAX_HITS) begin
          el_sel[n] = i; el_x[n] = s_x[i]; el_row[n] = (m_line - s_y[i]) % 16;
          el_attr[n] = s_attr[i]; el_pos[n] = s_pos[i];
        end
        n++;
      end
    end
    el_count = (n < MAX_HITS) ? n : MAX_HITS;
    sum_exp_q.push_back({4'(el_count), (n > MAX_HITS) ? 1'b1 : 1'b0});
  endtask

  // ---------------- driver ----------------
  // Advance one clock; the model observes this cycle's inputs first.
  task automatic tick();
    if (line_start) begin
      scanning = 1; scan_k = 0; m_line = int'(line_y);
    end else if (scanning != 0) begin
      s_vis[scan_k] = m_vis[scan_k]; s_y[scan_k] = m_y[scan_k];
      s_x[scan_k] = m_x[scan_k]; s_attr[scan_k] = m_attr[scan_k];
      s_pos[scan_k] = m_pos[scan_k];
      scan_k++;
      if (scan_k == 32) begin
        scanning = 0;
        model_finish_scan();
      end
    end
    if (sprite_wr) begin
      m_vis[sprite_sel] = int'(sprite_vis); m_y[sprite_sel] = int'(sprite_y);
      m_x[sprite_sel] = int'(sprite_x); m_attr[sprite_sel] = int'(sprite_attr);
      m_pos[sprite_sel] = int'(sprite_pos);
    end
    @(posedge clk);
    #1;
    sprite_wr  = 1'b0;
    line_start = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic set_wr(input int sel, input int x, input int y, input int vis,
                        input int attr, input int pos);
    sprite_wr = 1'b1; sprite_sel = 5'(sel); sprite_x = 10'(x); sprite_y = 9'(y);
    sprite_vis = 1'(vis); sprite_attr = 1'(attr); sprite_pos = 1'(pos);
  endtask

  task automatic wr_entry(input int sel, input int x, input int y, input int vis,
                          input int attr, input int pos);
    set_wr(sel, x, y, vis, attr, pos);
    tick();
  endtask

  task automatic start_line(input int y);
    line_start = 1'b1;
    line_y     = 9'(y);
    tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!list_valid && n < 80) begin
      tick();
      n++;
    end
    check("list_valid_done", int'(list_valid), 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < MAX_HITS; i++) begin
      rd_idx = 3'(i);
      rd_req = 1'b1;
      if (i < el_count)
        rd_exp_q.push_back({5'(el_sel[i]), 10'(el_x[i]), 4'(el_row[i]),
                            1'(el_attr[i]), 1'(el_pos[i])});
      else
        rd_exp_q.push_back('0);
      tick();
    end
    tick();
  endtask

  task automatic scan_line(input int y);
    start_line(y);
    wait_done();
    read_all();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_list_valid"}, int'(list_valid), 0);
    check({tag, "_hit_count"}, int'(hit_count), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_rd_bus"}, int'({rd_sel, rd_x, rd_row, rd_attr, rd_pos}), 0);
    check({tag, "_state"}, int'(dbg_state), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_outputs_zero(tag);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   start_cyc = 0;
  logic rd_req_d = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rd_req_d = rd_req;
    if (reset && line_start) start_cyc = cyc;
  end

  always @(negedge clk) begin
    logic [4:0]  es;
    logic [20:0] er;
    if (list_valid && !prev_valid) begin
      check("scan_latency", cyc - start_cyc, 32);
      check("list_pending", sum_exp_q.size(), 1);
      if (sum_exp_q.size() > 0) begin
        es = sum_exp_q.pop_front();
        check("hit_count", int'(hit_count), int'(es[4:1]));
        check("overflow", int'(overflow), int'(es[0]));
      end
    end
    prev_valid = list_valid;
    if (rd_req_d) begin
      check("rd_pending", int'(rd_exp_q.size() > 0), 1);
      if (rd_exp_q.size() > 0) begin
        er = rd_exp_q.pop_front();
        check("rd_entry", int'({rd_sel, rd_x, rd_row, rd_attr, rd_pos}), int'(er));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int line, yy, steps;
    model_clear();
    #2;
    do_reset("reset0");

    // Empty table
    scan_line(0);

    // Single sprite, row offsets and bottom edge
    wr_entry(3, 100, 50, 1, 1, 0);
    scan_line(57);
    scan_line(65);
    scan_line(66);
    scan_line(49);

    // More than MAX_HITS covering sprites
    do_reset("reset1");
    for (int i = 0; i < 10; i++) wr_entry(i, 10 * i + 1, 20, 1, i % 2, (i / 2) % 2);
    scan_line(20);
    scan_line(35);

    // Invisible entry and no wrap past line 511
    wr_entry(5, 7, 10, 0, 0, 0);
    wr_entry(6, 8, 500, 1, 0, 0);
    scan_line(12);
    scan_line(4);
    scan_line(505);

    // Abort: second request at cycle 10
    do_reset("reset2");
    wr_entry(3, 100, 50, 1, 0, 1);
    start_line(57);
    for (int i = 0; i < 9; i++) tick();
    start_line(30);
    wait_done();
    read_all();

    // Reset at cycle 15 of a scan
    start_line(57);
    for (int i = 0; i < 14; i++) tick();
    do_reset("reset_mid");
    scan_line(57);

    // Randomized: table fill near the line, writes and restarts during scans
    for (int it = 0; it < 30; it++) begin
      line = (it % 5 == 0) ? $urandom_range(495, 511) : $urandom_range(0, 511);
      for (int i = 0; i < 24; i++) begin
        yy = (line - int'($urandom_range(0, 20))) & 511;
        wr_entry($urandom_range(0, 31), $urandom_range(0, 1023), yy,
                 ($urandom_range(0, 9) < 8) ? 1 : 0, $urandom_range(0, 1),
                 $urandom_range(0, 1));
      end
      start_line(line);
      steps = 0;
      while (!list_valid && steps < 80) begin
        if ($urandom_range(0, 1) == 1) begin
          yy = (line - int'($urandom_range(0, 20))) & 511;
          set_wr($urandom_range(0, 31), $urandom_range(0, 1023), yy,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        if (steps < 20 && $urandom_range(0, 99) < 3) begin
          line_start = 1'b1;
          line_y     = 9'(line);
        end
        tick();
        steps++;
      end
      check("rand_list_valid", int'(list_valid), 1);
      read_all();
    end

    check("sum_queue_drained", sum_exp_q.size(), 0);
    check("rd_queue_drained", rd_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_scan.md
# sprite_line_scan

Sprite line scanner downstream of the execute stage's sprite write port. Holds the 32-entry sprite attribute table written by sprite instructions (sel, x, y, visible, attr, pos). On each scanline request it walks the table and builds an ordered list of up to MAX_HITS sprites covering that line. The pixel renderer reads this list through a registered read port.

## Interface
- SPR_H, 16, sprite height in lines; power of two, max 16
- MAX_HITS, 8, max sprites per line; list depth
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sprite_wr  in  1  table write strobe, one cycle per write
- sprite_sel  in  5  table entry index
- sprite_x  in  10  sprite x position
- sprite_y  in  9  sprite top line
- sprite_vis  in  1  visible flag
- sprite_attr  in  1  attribute bit, passed to renderer
- sprite_pos  in  1  priority bit, passed to renderer
- line_start  in  1  single-cycle scan request
- line_y  in  9  line to scan, sampled with line_start
- rd_idx  in  3  list read index, clog2(MAX_HITS) bits
- list_valid  out  1  list complete for the current line
- hit_count  out  4  number of list entries, 0..MAX_HITS
- overflow  out  1  more than MAX_HITS sprites matched the line
- rd_sel  out  5  entry index of list[rd_idx]
- rd_x  out  10  x of list[rd_idx]
- rd_row  out  4  line_y minus sprite_y for list[rd_idx]
- rd_attr  out  1  attr of list[rd_idx]
- rd_pos  out  1  pos of list[rd_idx]

## Operation
- Table: 32 entries of 22 bits. On sprite_wr, all fields are written to entry sprite_sel at the clock edge. Writes are accepted in every state.
- FSM states: IDLE, SCAN, DONE.
  - IDLE or DONE with line_start: latch line_y, set scan_idx to 0, clear hit_count and overflow, drop list_valid, go to SCAN.
  - SCAN: evaluate entry scan_idx each cycle. After entry 31, go to DONE and set list_valid.
  - DONE: hold the list until the next line_start.
- Hit condition: vis = 1 and y <= line_y < y + SPR_H. The comparison uses 10-bit unsigned arithmetic, so there is no wrap past line 511.
- On a hit with hit_count < MAX_HITS: append {index, x, line_y - y (low 4 bits), attr, pos} and increment hit_count.
- On a hit with hit_count = MAX_HITS: set overflow sticky for this line. The list is unchanged.
- List order is ascending table index; the lowest index comes first.
- Scan write collision: a write to entry scan_idx in the cycle that entry is evaluated is not seen. The scan uses the pre-write value; the write still lands.
- line_start during SCAN aborts the scan and restarts with the new line_y. list_valid stays low.
- Read port: rd_* are registered from list[rd_idx]. If rd_idx >= hit_count, all rd_* are 0. The read port works in any state; its output is meaningful only while list_valid = 1.

## Timing
- Reset (asynchronous, immediate): every table entry is cleared (vis = 0). State is IDLE. list_valid, hit_count, overflow and all rd_* are 0.
- Scan latency: line_start is sampled at edge E0. Entry k is appended at edge E(k+1). list_valid rises at E32, so results are visible 32 cycles after the request.
- Read latency: 1 cycle from rd_idx to rd_*.
- A write is visible to any scan evaluation in the cycle after the write edge.
- Reset mid-scan: the scan is abandoned and all outputs are 0. The next line_start starts a fresh scan.

## Structure
- Shared package sprite_pkg holds:
  - NUM_SPRITES = 32
  - field widths X_W = 10, Y_W = 9, SEL_W = 5, ROW_W = 4
  - entry struct {vis, attr, pos, y, x}
  - FSM enum {IDLE, SCAN, DONE}
  - list-entry struct {sel, x, row, attr, pos}
- Sub-module sprite_table: 32x22 flop array with a synchronous write port, an asynchronous read port and asynchronous clear.
- Top level: FSM, hit comparator, list registers and read mux.

## Test plan
- Reset, then line_start with line_y = 0 on the empty table: list_valid = 0 for 32 cycles, then 1. hit_count = 0, overflow = 0.
- Write entry 3 with x = 100, y = 50, vis = 1, then scan line_y = 57: hit_count = 1. rd_idx = 0 gives rd_sel = 3, rd_x = 100, rd_row = 7. line_y = 65 gives rd_row = 15. line_y = 66 gives hit_count = 0.
- Entries 0..9 visible with y = 20, scan line_y = 20: hit_count = 8, overflow = 1. rd_idx 0..7 returns rd_sel 0..7 in order. rd_idx beyond hit_count returns zeros.
- Entry 5 with vis = 0 and y = 10 scanned at line_y = 12: no hit. Entry 6 with y = 500 and vis = 1 scanned at line_y = 4: no hit, since there is no wrap.
- line_start for line_y = 57 with entry 3 from above, then a second line_start with line_y = 30 at cycle 10: list_valid stays low until 32 cycles after the second request. hit_count = 0.
- Reset asserted mid-scan at cycle 15: all outputs are 0 at once and every entry reads back invisible, so a following scan gives hit_count = 0.
